// File: rtl/sm_to_twos_serial_pkg.sv
// Shared constants for the sign-magnitude / two's complement serial converters:
// FSM state encoding and the default word width.
package sm_to_twos_serial_pkg;

    localparam int SM2TC_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } sm2tc_state_t;

    // Bits needed to count bit positions 0..width-2 of a word.
    function automatic int sm2tc_idx_width(input int width);
        return (width > 2) ? $clog2(width - 1) : 1;
    endfunction

endpackage

// File: rtl/sm_to_twos_serial_adder.sv
// One-bit full adder used as the serial bit slice of the converter datapath.
module adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/sm_to_twos_serial.sv
// Bit-serial sign-magnitude to two's complement converter, one magnitude bit per clock.
// Optional macro SM2TC_NEGZERO_FLAG_EN adds the registered neg_zero output.
module sm_to_twos_serial
    import sm_to_twos_serial_pkg::*;
#(
    parameter int WIDTH = SM2TC_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_sm,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_tc,
    output logic             out_valid,
`ifdef SM2TC_NEGZERO_FLAG_EN
    output logic             neg_zero,
`endif
    input  logic             out_ready
);

    localparam int IDX_W = sm2tc_idx_width(WIDTH);

    sm2tc_state_t     state_r;
    logic [WIDTH-1:0] operand_r;
    logic [WIDTH-1:0] out_tc_r;
    logic [IDX_W-1:0] idx_r;
    logic             carry_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic             sign_s;
    logic             t_s;
    logic             sum_s;
    logic             cout_s;
    logic             last_bit_s;
    logic             accept_s;

`ifdef SM2TC_NEGZERO_FLAG_EN
    logic             neg_zero_r;
`endif

    assign sign_s     = operand_r[WIDTH-1];
    assign t_s        = operand_r[idx_r] ^ sign_s;
    assign last_bit_s = (idx_r == IDX_W'(WIDTH - 2));
    assign accept_s   = in_valid & in_ready_r;

    // Serial bit slice: the incoming sign acts as the +1 of the negation.
    adder u_adder (
        .a     (t_s),
        .b     (1'b0),
        .c_in  (carry_r),
        .s     (sum_s),
        .c_out (cout_s)
    );

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            operand_r   <= {WIDTH{1'b0}};
            out_tc_r    <= {WIDTH{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            carry_r     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef SM2TC_NEGZERO_FLAG_EN
            neg_zero_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        operand_r  <= in_sm;
                        carry_r    <= in_sm[WIDTH-1];
                        idx_r      <= {IDX_W{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= ST_CONV;
`ifdef SM2TC_NEGZERO_FLAG_EN
                        neg_zero_r <= in_sm[WIDTH-1] &
                                      (in_sm[WIDTH-2:0] == {(WIDTH-1){1'b0}});
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    out_tc_r[idx_r] <= sum_s;
                    carry_r         <= cout_s;
                    idx_r           <= idx_r + IDX_W'(1'b1);
                    // The final carry cancels the sign for negative zero.
                    if (last_bit_s) begin
                        out_tc_r[WIDTH-1] <= sign_s ^ cout_s;
                        out_valid_r       <= 1'b1;
                        state_r           <= ST_DONE;
                    end else begin
                        state_r <= ST_CONV;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
`ifdef SM2TC_NEGZERO_FLAG_EN
                        neg_zero_r  <= 1'b0;
`endif
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_tc    = out_tc_r;
`ifdef SM2TC_NEGZERO_FLAG_EN
    assign neg_zero  = neg_zero_r;
`endif

endmodule

// File: tb/tb_sm_to_twos_serial.sv
// Directed self-checking bench for sm_to_twos_serial (WIDTH = 8).
module tb_sm_to_twos_serial;

    logic       clk;
    logic       reset;
    logic [7:0] in_sm;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_tc;
    logic       out_valid;
    logic       out_ready;
`ifdef SM2TC_NEGZERO_FLAG_EN
    logic       neg_zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sm_to_twos_serial #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_sm     (in_sm),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_tc    (out_tc),
        .out_valid (out_valid),
`ifdef SM2TC_NEGZERO_FLAG_EN
        .neg_zero  (neg_zero),
`endif
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operand and hold it until the accept edge (bounded).
    task automatic accept(input logic [7:0] op);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        in_sm    = op;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count cycles until out_valid, bounded at 30.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 30) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sm     = 8'h00;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %0b required 0", out_valid);
        end
        n_checks++;
        if (out_tc !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out_tc: got %h required 00", out_tc);
        end
    endtask

    task automatic test_positive();
        int cyc;
        logic [7:0] ops [2];
        ops[0] = 8'h05;
        ops[1] = 8'h7F;
        for (int i = 0; i < 2; i++) begin
            accept(ops[i]);
            wait_valid(cyc);
            n_checks++;
            if (cyc !== 7) begin
                n_fail++;
                $display("FAIL pos_latency[%0d]: got %0d required 7", i, cyc);
            end
            n_checks++;
            if (out_tc !== ops[i]) begin
                n_fail++;
                $display("FAIL pos_value[%0d]: got %h required %h", i, out_tc, ops[i]);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL pos_release[%0d]: out_valid=%0b in_ready=%0b required 0/1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_negative();
        int cyc;
        logic [7:0] ops [2];
        logic [7:0] exp [2];
        ops[0] = 8'h85; exp[0] = 8'hFB;
        ops[1] = 8'hFF; exp[1] = 8'h81;
        for (int i = 0; i < 2; i++) begin
            accept(ops[i]);
            wait_valid(cyc);
            n_checks++;
            if (cyc !== 7) begin
                n_fail++;
                $display("FAIL neg_latency[%0d]: got %0d required 7", i, cyc);
            end
            n_checks++;
            if (out_tc !== exp[i]) begin
                n_fail++;
                $display("FAIL neg_value[%0d]: got %h required %h", i, out_tc, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_neg_zero();
        int cyc;
        logic [7:0] ops [2];
        logic       nz [2];
        ops[0] = 8'h80; nz[0] = 1'b1;
        ops[1] = 8'h00; nz[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            accept(ops[i]);
            wait_valid(cyc);
            n_checks++;
            if (out_tc !== 8'h00) begin
                n_fail++;
                $display("FAIL zero_value[%0d]: got %h required 00", i, out_tc);
            end
`ifdef SM2TC_NEGZERO_FLAG_EN
            n_checks++;
            if (neg_zero !== nz[i]) begin
                n_fail++;
                $display("FAIL zero_flag[%0d]: got %0b required %0b", i, neg_zero, nz[i]);
            end
`endif
            tick();
`ifdef SM2TC_NEGZERO_FLAG_EN
            n_checks++;
            if (neg_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_flag_clear[%0d]: got %0b required 0", i, neg_zero);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready = 1'b0;
        accept(8'h83);
        wait_valid(cyc);
        for (int i = 0; i < 5; i++) begin
            in_sm    = 8'h11;
            in_valid = i[0];
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_tc !== 8'hFD || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: out_valid=%0b out_tc=%h in_ready=%0b required 1/fd/0",
                         i, out_valid, out_tc, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: out_valid=%0b in_ready=%0b required 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        accept(8'h9A);
        tick();
        tick();
        tick();
        reset    = 1'b1;
        in_sm    = 8'h55;
        in_valid = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_tc !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: in_ready=%0b out_valid=%0b out_tc=%h required 1/0/00",
                     in_ready, out_valid, out_tc);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ignores_valid: in_ready=%0b required 1", in_ready);
        end
        accept(8'h01);
        wait_valid(cyc);
        n_checks++;
        if (cyc !== 7 || out_tc !== 8'h01) begin
            n_fail++;
            $display("FAIL post_reset_conv: latency=%0d out_tc=%h required 7/01", cyc, out_tc);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        in_sm    = 8'h81;
        in_valid = 1'b1;
        tick();
        in_sm = 8'h02;
        wait_valid(cyc);
        n_checks++;
        if (cyc !== 7 || out_tc !== 8'hFF) begin
            n_fail++;
            $display("FAIL b2b_first: latency=%0d out_tc=%h required 7/ff", cyc, out_tc);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        wait_valid(cyc);
        n_checks++;
        if (cyc !== 7 || out_tc !== 8'h02) begin
            n_fail++;
            $display("FAIL b2b_second: latency=%0d out_tc=%h required 7/02", cyc, out_tc);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_positive();
        test_negative();
        test_neg_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
